// File: rtl/apb_fifo_wr_if.sv
// APB slave bus bundle for the apb_fifo_wr push port.
interface apb_fifo_wr_if #(
  parameter int DATA_W = 32
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [3:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_fifo_wr.sv
// APB-written FIFO: pushes via DATA register, status/flush via registers,
// drains through a pop strobe against an external combinational-read memory.
module apb_fifo_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  apb_fifo_wr_if.slave      apb,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_ra,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count;
  logic [1:0]      reg_sel;
  logic            empty, full;
  logic            access, push, pop_fire, flush;
  logic            unused_addr_bits;

  assign reg_sel          = apb.paddr[3:2];
  assign unused_addr_bits = ^apb.paddr[1:0];

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                 (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  // Side effects fire only in the access phase while the master still selects us.
  assign access   = (state_q == ST_ACCESS) && apb.psel;
  assign push     = access && apb.pwrite && (reg_sel == REG_DATA) && !full;
  assign flush    = access && apb.pwrite && (reg_sel == REG_CTRL) && apb.pwdata[0];
  assign pop_fire = pop && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (apb.psel && !apb.penable) state_d = ST_SETUP;
      ST_SETUP:  state_d = apb.psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = (apb.psel && !apb.penable) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push)     wptr_d = wptr_q + 1'b1;
      if (pop_fire) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign apb.pready = (state_q == ST_ACCESS);

  always_comb begin
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (apb.pready) begin
      case (reg_sel)
        REG_DATA:   apb.pslverr = apb.pwrite && full;
        REG_STATUS: if (!apb.pwrite) begin
          apb.prdata[0]            = empty;
          apb.prdata[1]            = full;
          apb.prdata[8 +: ADDR_W+1] = count;
        end
        REG_RSVD:   apb.pslverr = 1'b1;
        default:    apb.pslverr = 1'b0;
      endcase
    end
  end

  assign mem_we    = push;
  assign mem_wa    = wptr_q[ADDR_W-1:0];
  assign mem_wd    = apb.pwdata;
  assign mem_ra    = rptr_q[ADDR_W-1:0];
  assign pop_valid = !empty;
  assign pop_data  = mem_rd;

endmodule

// File: tb/tb_apb_fifo_wr.sv
// Directed bench for apb_fifo_wr with a behavioural 256-word memory.
module tb_apb_fifo_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_wa, mem_ra;
  logic [31:0] mem_wd, mem_rd, pop_data;
  logic        mem_we, pop_valid, pop;

  always #5 clk = ~clk;

  apb_fifo_wr_if #(.DATA_W(32)) apb ();

  apb_fifo_wr #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_ra    (mem_ra),
    .mem_rd    (mem_rd),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .pop       (pop)
  );

  logic [31:0] mem [256];
  int unsigned we_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
      we_cnt++;
    end
  end
  assign mem_rd = mem[mem_ra];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] rd, wd;
  logic        er, we;
  logic [7:0]  wa;

  // One full 3-cycle transfer; results are sampled mid-cycle in the access phase.
  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic pop_in);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    pop = pop_in;
    #1;
    check("pready", {31'd0, apb.pready}, 32'd1);
    rd = apb.prdata; er = apb.pslverr; we = mem_we; wa = mem_wa; wd = mem_wd;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; pop = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    apb_xfer(1'b0, 4'h4, 32'd0, 1'b0);
    check(tag, rd, exp);
  endtask

  task automatic do_pop();
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int unsigned w0;

  initial begin
    rst = 1'b1; pop = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_pready",    {31'd0, apb.pready},  32'd0);
    check("rst_pslverr",   {31'd0, apb.pslverr}, 32'd0);
    check("rst_prdata",    apb.prdata,           32'd0);
    check("rst_mem_we",    {31'd0, mem_we},      32'd0);
    check("rst_pop_valid", {31'd0, pop_valid},   32'd0);
    rst = 1'b0;

    // first push
    apb_xfer(1'b1, 4'h0, 32'hA5A5_A5A5, 1'b0);
    check("p1_we",  {31'd0, we}, 32'd1);
    check("p1_wa",  {24'd0, wa}, 32'd0);
    check("p1_wd",  wd,          32'hA5A5_A5A5);
    check("p1_err", {31'd0, er}, 32'd0);
    #1;
    check("p1_pop_valid", {31'd0, pop_valid}, 32'd1);
    check("p1_pop_data",  pop_data,           32'hA5A5_A5A5);
    read_status("p1_status", 32'h0000_0100);

    // register map corners
    apb_xfer(1'b0, 4'h0, 32'd0, 1'b0);
    check("rd_data", rd, 32'd0); check("rd_data_err", {31'd0, er}, 32'd0);
    apb_xfer(1'b0, 4'h8, 32'd0, 1'b0);
    check("rd_ctrl", rd, 32'd0); check("rd_ctrl_err", {31'd0, er}, 32'd0);
    apb_xfer(1'b0, 4'hC, 32'd0, 1'b0);
    check("rd_rsvd", rd, 32'd0); check("rd_rsvd_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b1, 4'hC, 32'h1234_5678, 1'b0);
    check("wr_rsvd_err", {31'd0, er}, 32'd1); check("wr_rsvd_we", {31'd0, we}, 32'd0);

    apb_xfer(1'b1, 4'h8, 32'h1, 1'b0);
    read_status("flush_status", 32'h0000_0001);
    check("flush_ra", {24'd0, mem_ra}, 32'd0);

    // fill to full
    for (int unsigned i = 0; i < 256; i++) begin
      apb_xfer(1'b1, 4'h0, pat(i), 1'b0);
      check("fill_wa", {24'd0, wa}, i);
    end
    read_status("full_status", 32'h0001_0002);
    apb_xfer(1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0);
    check("ovf_err", {31'd0, er}, 32'd1);
    check("ovf_we",  {31'd0, we}, 32'd0);
    read_status("ovf_status", 32'h0001_0002);

    // drain
    for (int unsigned i = 0; i < 256; i++) begin
      #1;
      check("drain_data", pop_data, pat(i));
      do_pop();
    end
    #1;
    check("drain_pop_valid", {31'd0, pop_valid}, 32'd0);
    check("drain_ra", {24'd0, mem_ra}, 32'd0);
    read_status("drain_status", 32'h0000_0001);

    // pointers wrapped: next push lands at address 0
    apb_xfer(1'b1, 4'h0, 32'hBEEF_0001, 1'b0);
    check("wrap_wa", {24'd0, wa}, 32'd0);
    check("wrap_we", {31'd0, we}, 32'd1);
    #1;
    check("wrap_pop_data", pop_data, 32'hBEEF_0001);
    read_status("wrap_status", 32'h0000_0100);

    // push and pop together at count 5
    for (int unsigned k = 1; k <= 4; k++) apb_xfer(1'b1, 4'h0, 32'hC0DE_0000 + k, 1'b0);
    read_status("c5_status", 32'h0000_0500);
    apb_xfer(1'b1, 4'h0, 32'hC0DE_0005, 1'b1);
    check("pp_we", {31'd0, we}, 32'd1);
    check("pp_wa", {24'd0, wa}, 32'd5);
    read_status("pp_status", 32'h0000_0500);
    check("pp_ra", {24'd0, mem_ra}, 32'd1);
    check("pp_pop_data", pop_data, 32'hC0DE_0001);

    // flush beats a simultaneous pop at count 10
    for (int unsigned k = 0; k < 5; k++) apb_xfer(1'b1, 4'h0, 32'hF00D_0000 + k, 1'b0);
    read_status("c10_status", 32'h0000_0A00);
    apb_xfer(1'b1, 4'h8, 32'h1, 1'b1);
    read_status("fp_status", 32'h0000_0001);
    check("fp_ra", {24'd0, mem_ra}, 32'd0);
    check("fp_pop_valid", {31'd0, pop_valid}, 32'd0);

    do_pop();
    read_status("pop_empty_status", 32'h0000_0001);
    check("pop_empty_ra", {24'd0, mem_ra}, 32'd0);

    // full write with simultaneous pop must not push
    for (int unsigned i = 0; i < 256; i++) apb_xfer(1'b1, 4'h0, pat(i), 1'b0);
    read_status("refill_status", 32'h0001_0002);
    apb_xfer(1'b1, 4'h0, 32'h5555_AAAA, 1'b1);
    check("fullpop_err", {31'd0, er}, 32'd1);
    check("fullpop_we",  {31'd0, we}, 32'd0);
    read_status("fullpop_status", 32'h0000_FF00);

    // aborted setup of a flush, then of a push
    apb_xfer(1'b1, 4'h8, 32'h1, 1'b0);
    apb_xfer(1'b1, 4'h0, 32'h0BAD_0001, 1'b0);
    w0 = we_cnt;
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 4'h8; apb.pwdata = 32'h1;
    @(negedge clk);
    apb.psel = 1'b0;
    check("abort_pready_setup", {31'd0, apb.pready}, 32'd0);
    @(negedge clk);
    check("abort_pready_idle", {31'd0, apb.pready}, 32'd0);
    apb.psel = 1'b1; apb.paddr = 4'h0; apb.pwdata = 32'h0BAD_0002;
    @(negedge clk);
    apb.psel = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_we_cnt", we_cnt, w0);
    read_status("abort_status", 32'h0000_0100);

    // reset during the access phase of a push
    w0 = we_cnt;
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 4'h0; apb.pwdata = 32'h7777_0000;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    #1;
    check("rstx_pready_pre", {31'd0, apb.pready}, 32'd1);
    check("rstx_we_pre",     {31'd0, mem_we},     32'd1);
    rst = 1'b1;
    #1;
    check("rstx_we",        {31'd0, mem_we},     32'd0);
    check("rstx_pready",    {31'd0, apb.pready}, 32'd0);
    check("rstx_pop_valid", {31'd0, pop_valid},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstx_idle_pready", {31'd0, apb.pready}, 32'd0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge clk);
    check("rstx_we_cnt", we_cnt, w0);
    read_status("rstx_status", 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
